alu_seq: RTL and testbench

- Parametrised, registered successor to the 8-bit combinational ALU datapath; supports the same four operations at WIDTH bits.
- Shift operations gain a variable shift amount, executed iteratively one bit per cycle.
- Adds valid/ready handshakes on both sides and registered status flags.
- Sits between an operand source and a result consumer in the datapath; one operation in flight at a time.

---
 rtl/alu_seq.sv | 141 ++++++++++++++
 tb/tb_alu_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered, handshaked ALU: half-add, subtract, and iterative one-bit-per-cycle
// logical shifts. One operation in flight; the result is held until the consumer takes it.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       mode,
    input  logic [SHW-1:0]   shamt,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             Z
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             c_q, c_d;
    logic             v_q, v_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;

    logic             accept;
    logic [WIDTH:0]   sum_half;
    logic [WIDTH:0]   sum_sub;

    assign accept   = in_vld & in_rdy;
    assign sum_half = {2'b00, A[WIDTH-1:1]} + {1'b0, B};
    // Extra top bit captures carry-out, i.e. "no borrow" for the subtract.
    assign sum_sub  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mode[1] && (shamt != '0)) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_rdy  = (state_q == IDLE);
        out_vld = (state_q == DONE);
    end

    always_comb begin
        y_d    = y_q;
        c_d    = c_q;
        v_d    = v_q;
        cnt_d  = cnt_q;
        left_d = left_q;
        if (accept) begin
            case (mode)
                2'b00: begin
                    y_d = sum_half[WIDTH-1:0];
                    c_d = sum_half[WIDTH];
                    v_d = 1'b0;
                end
                2'b01: begin
                    y_d = sum_sub[WIDTH-1:0];
                    c_d = sum_sub[WIDTH];
                    v_d = (A[WIDTH-1] != B[WIDTH-1]) & (sum_sub[WIDTH-1] != A[WIDTH-1]);
                end
                default: begin
                    y_d    = A;
                    c_d    = 1'b0;
                    v_d    = 1'b0;
                    cnt_d  = shamt;
                    left_d = mode[0];
                end
            endcase
        end else if (state_q == SHIFT) begin
            if (left_q) begin
                y_d = {y_q[WIDTH-2:0], 1'b0};
                c_d = y_q[WIDTH-1];
            end else begin
                y_d = {1'b0, y_q[WIDTH-1:1]};
                c_d = y_q[0];
            end
            cnt_d = cnt_q - SHW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q    <= '0;
            c_q    <= 1'b0;
            v_q    <= 1'b0;
            cnt_q  <= '0;
            left_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            c_q    <= c_d;
            v_q    <= v_d;
            cnt_q  <= cnt_d;
            left_q <= left_d;
        end
    end

    assign Y = y_q;
    assign C = c_q;
    assign V = v_q;
    assign N = y_q[WIDTH-1];
    assign Z = (y_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed literal cases plus randomized operations checked against
// an arithmetic reference model; outputs are compared every cycle a result is presented.
module tb_alu_seq;

    localparam int W  = 8;
    localparam int SW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic          out_rdy = 1'b0;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic [1:0]    mode = '0;
    logic [SW-1:0] shamt = '0;
    logic          in_rdy, out_vld, C, V, N, Z;
    logic [W-1:0]  Y;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_y = '0;
    logic         exp_c = 1'b0;
    logic         exp_v = 1'b0;
    bit           cmp_en = 1'b0;

    alu_seq #(.WIDTH(W), .SHW(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .A(A), .B(B), .mode(mode), .shamt(shamt),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .Y(Y), .C(C), .V(V), .N(N), .Z(Z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model straight from the arithmetic definition of each mode.
    task automatic model(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int s, output logic [W-1:0] y, output logic c,
                         output logic v, output int lat);
        int sum, sa, sb, sd;
        y = '0; c = 1'b0; v = 1'b0; lat = 1;
        case (m)
            2'b00: begin
                sum = int'(a >> 1) + int'(b);
                y   = W'(sum % (1 << W));
                c   = (sum >= (1 << W));
            end
            2'b01: begin
                sum = int'(a) - int'(b);
                y   = W'((sum + (1 << W)) % (1 << W));
                c   = (a >= b);
                sa  = (a >= (1 << (W-1))) ? int'(a) - (1 << W) : int'(a);
                sb  = (b >= (1 << (W-1))) ? int'(b) - (1 << W) : int'(b);
                sd  = sa - sb;
                v   = (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
            end
            2'b10: begin
                y   = a >> s;
                c   = (s == 0) ? 1'b0 : a[s-1];
                lat = s + 1;
            end
            default: begin
                y   = a << s;
                c   = (s == 0) ? 1'b0 : a[W-s];
                lat = s + 1;
            end
        endcase
    endtask

    // Single compare process: whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (cmp_en && rst_n && out_vld) begin
            chk("Y", {24'd0, Y}, {24'd0, exp_y});
            chk("C", {31'd0, C}, {31'd0, exp_c});
            chk("V", {31'd0, V}, {31'd0, exp_v});
            chk("N", {31'd0, N}, {31'd0, exp_y[W-1]});
            chk("Z", {31'd0, Z}, {31'd0, (exp_y == '0)});
            chk("in_rdy_in_done", {31'd0, in_rdy}, 32'd0);
        end
    end

    // Called at a negedge; returns at a negedge after the output handshake.
    task automatic do_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int s, input int hold, input bit use_lit,
                         input logic [W-1:0] ly, input logic lc, input logic lv, input int llat);
        logic [W-1:0] my;
        logic         mc, mv;
        int           mlat, lat, guard;
        model(m, a, b, s, my, mc, mv, mlat);
        guard = 0;
        while (!in_rdy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("in_rdy_idle", {31'd0, in_rdy}, 32'd1);
        A = a; B = b; mode = m; shamt = SW'(s);
        in_vld = 1'b1;
        exp_y = my; exp_c = mc; exp_v = mv;
        @(posedge clk);
        #1;
        // Scramble inputs after accept; they must have no effect.
        in_vld = 1'($urandom_range(0, 1));
        A = W'($urandom); B = W'($urandom); mode = 2'($urandom); shamt = SW'($urandom);
        lat = 1;
        @(negedge clk);
        while (!out_vld && lat < 40) begin
            chk("in_rdy_busy", {31'd0, in_rdy}, 32'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, mlat);
        if (use_lit) begin
            chk("lit_latency", lat, llat);
            chk("lit_Y", {24'd0, Y}, {24'd0, ly});
            chk("lit_C", {31'd0, C}, {31'd0, lc});
            chk("lit_V", {31'd0, V}, {31'd0, lv});
        end
        for (int i = 0; i < hold; i++) begin
            in_vld = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        out_rdy = 1'b1;
        in_vld  = 1'b0;
        @(negedge clk);
        out_rdy = 1'b0;
        chk("in_rdy_after_hs", {31'd0, in_rdy}, 32'd1);
        chk("out_vld_after_hs", {31'd0, out_vld}, 32'd0);
        $display("op mode=%0d A=%02h B=%02h shamt=%0d hold=%0d -> Y=%02h C=%0d V=%0d lat=%0d (exp Y=%02h C=%0d V=%0d lat=%0d)",
                 m, a, b, s, hold, my, mc, mv, lat, my, mc, mv, mlat);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_Y", {24'd0, Y}, 32'd0);
        chk("rst_Z", {31'd0, Z}, 32'd1);
        chk("rst_N", {31'd0, N}, 32'd0);
        chk("rst_C", {31'd0, C}, 32'd0);
        chk("rst_V", {31'd0, V}, 32'd0);
        chk("rst_out_vld", {31'd0, out_vld}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
        cmp_en = 1'b1;

        // Directed cases with hand-computed results
        do_op(2'b00, 8'h10, 8'h05, 0, 0, 1'b1, 8'h0D, 1'b0, 1'b0, 1);
        do_op(2'b00, 8'hFE, 8'h90, 0, 1, 1'b1, 8'h0F, 1'b1, 1'b0, 1);
        do_op(2'b01, 8'h05, 8'h05, 0, 0, 1'b1, 8'h00, 1'b1, 1'b0, 1);
        do_op(2'b01, 8'h03, 8'h05, 0, 0, 1'b1, 8'hFE, 1'b0, 1'b0, 1);
        do_op(2'b01, 8'h80, 8'h01, 0, 0, 1'b1, 8'h7F, 1'b1, 1'b1, 1);
        do_op(2'b11, 8'h81, 8'h3C, 3, 0, 1'b1, 8'h08, 1'b0, 1'b0, 4);
        do_op(2'b10, 8'h81, 8'hC3, 1, 0, 1'b1, 8'h40, 1'b1, 1'b0, 2);
        do_op(2'b10, 8'hA5, 8'h11, 0, 0, 1'b1, 8'hA5, 1'b0, 1'b0, 1);
        do_op(2'b11, 8'h01, 8'h22, 7, 0, 1'b1, 8'h80, 1'b0, 1'b0, 8);
        // Backpressure: held 5 cycles with junk in_vld
        do_op(2'b01, 8'h7F, 8'hFF, 0, 5, 1'b1, 8'h80, 1'b0, 1'b1, 1);

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            do_op(2'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, W-1)),
                  int'($urandom_range(0, 3)), 1'b0, '0, 1'b0, 1'b0, 0);
        end

        // Asynchronous reset in the middle of a 6-step shift
        A = 8'h81; B = 8'h00; mode = 2'b11; shamt = SW'(6);
        in_vld = 1'b1;
        @(posedge clk);
        #1;
        in_vld = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_Y", {24'd0, Y}, 32'd0);
        chk("midrst_out_vld", {31'd0, out_vld}, 32'd0);
        chk("midrst_Z", {31'd0, Z}, 32'd1);
        chk("midrst_C", {31'd0, C}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_in_rdy", {31'd0, in_rdy}, 32'd1);
        repeat (6) @(negedge clk);
        chk("postrst_no_result", {31'd0, out_vld}, 32'd0);
        $display("op reset mid-shift: Y=%02h out_vld=%0d after release", Y, out_vld);
        do_op(2'b00, 8'h10, 8'h05, 0, 0, 1'b1, 8'h0D, 1'b0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
